// File: rtl/mult8_host_seq.sv
// ---------------------------------------------------------------------------
// mult8_host_seq
//
// Host-side master for the tt_um_mult8_shiftadd byte-serial multiplier.
// It takes an operand pair over a valid/ready handshake and pulses load_A,
// load_B and start, each followed by a one-cycle gap. It then waits for done,
// with a timeout, and reads the 16-bit product back low byte first. The
// result is presented on a valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge. ready never depends combinationally on valid.
//
// Parameters
//   TIMEOUT_CYCLES  maximum WAIT_DONE cycles before aborting (legal 2..255)
//
// Optional build feature
//   MULT8_HOST_SEQ_CHECK_EN  when defined, each product is checked against a
//                            local reference multiplier and the result is
//                            flagged on res_mismatch. When undefined,
//                            res_mismatch is tied to 0 and no multiplier is
//                            built.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   rst           synchronous, active-high reset
//   in_valid      operand pair valid
//   in_ready      sequencer can accept operands (IDLE only)
//   in_a, in_b    operands A and B
//   mul_ui        data byte to multiplier ui_in
//   mul_load_a    multiplier uio_in[0] strobe
//   mul_load_b    multiplier uio_in[1] strobe
//   mul_start     multiplier uio_in[2] strobe
//   mul_out_sel   multiplier uio_in[3]: 0 = low byte, 1 = high byte
//   mul_uo        multiplier uo_out
//   mul_done      multiplier uio_out[7]
//   res_valid     result valid
//   res_ready     downstream accepts result
//   res_data      product {hi, lo}, or 16'hFFFF after a timeout
//   res_err       this result was aborted by timeout
//   err_sticky    a timeout has occurred since reset
//   res_mismatch  product disagrees with the local reference (CHECK_EN only)
//
// The FSM state is the named register "state". All outputs are registered
// and decoded from the next state, so they behave as Moore outputs of the
// state register.
// ---------------------------------------------------------------------------
module mult8_host_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_ui,
  output logic        mul_load_a,
  output logic        mul_load_b,
  output logic        mul_start,
  output logic        mul_out_sel,
  input  logic [7:0]  mul_uo,
  input  logic        mul_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic        err_sticky,
  output logic        res_mismatch
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDA,
    S_LDA_GAP,
    S_LDB,
    S_LDB_GAP,
    S_START,
    S_START_GAP,
    S_WAIT_DONE,
    S_RD_LO_SET,
    S_RD_LO_CAP,
    S_RD_HI_SET,
    S_RD_HI_CAP,
    S_OUT
  } state_t;

  // The counter holds (WAIT_DONE cycles already spent). The cycle where it
  // equals TIMEOUT_CYCLES-1 is therefore the last one allowed.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;

  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  lo_q;
  logic [7:0]  wait_cnt;
  logic        armed;

  // Result register load, computed alongside the next state
  logic        result_load;
  logic [15:0] result_next;
  logic        result_err_next;

  logic        accept;
  logic        done_seen;

  assign accept    = (state == S_IDLE) && in_valid;
  // done only counts after it has been observed low since START. This skips
  // a done level left high by the previous operation.
  assign done_seen = mul_done && armed;

  // -------------------------------------------------------------------------
  // Next-state and result-load decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    result_load     = 1'b0;
    result_next     = 16'h0000;
    result_err_next = 1'b0;
    case (state)
      S_IDLE:      if (accept) state_next = S_LDA;
      S_LDA:       state_next = S_LDA_GAP;
      S_LDA_GAP:   state_next = S_LDB;
      S_LDB:       state_next = S_LDB_GAP;
      S_LDB_GAP:   state_next = S_START;
      S_START:     state_next = S_START_GAP;
      S_START_GAP: state_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // done wins over timeout if both happen in the same cycle
        if (done_seen) begin
          state_next = S_RD_LO_SET;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_next      = S_OUT;
          result_load     = 1'b1;
          result_next     = 16'hFFFF;
          result_err_next = 1'b1;
        end
      end
      S_RD_LO_SET: state_next = S_RD_LO_CAP;
      S_RD_LO_CAP: state_next = S_RD_HI_SET;
      S_RD_HI_SET: state_next = S_RD_HI_CAP;
      S_RD_HI_CAP: begin
        state_next  = S_OUT;
        result_load = 1'b1;
        result_next = {mul_uo, lo_q};
      end
      S_OUT:       if (res_ready) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      mul_ui      <= 8'h00;
      mul_load_a  <= 1'b0;
      mul_load_b  <= 1'b0;
      mul_start   <= 1'b0;
      mul_out_sel <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= 16'h0000;
      res_err     <= 1'b0;
      err_sticky  <= 1'b0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      lo_q        <= 8'h00;
      wait_cnt    <= 8'h00;
      armed       <= 1'b0;
    end else begin
      state       <= state_next;

      // Moore outputs, registered from the next state
      in_ready    <= (state_next == S_IDLE);
      mul_load_a  <= (state_next == S_LDA);
      mul_load_b  <= (state_next == S_LDB);
      mul_start   <= (state_next == S_START);
      mul_out_sel <= (state_next == S_RD_HI_SET) || (state_next == S_RD_HI_CAP);
      res_valid   <= (state_next == S_OUT);

      // Operand latch. mul_ui takes A straight from the port so the byte is
      // already valid during LDA. It is driven again from the latch on entry
      // to LDA_GAP and switches to B on entry to LDB. Otherwise it holds its
      // last value.
      if (accept) begin
        a_q    <= in_a;
        b_q    <= in_b;
        mul_ui <= in_a;
      end else if (state == S_LDA) begin
        mul_ui <= a_q;
      end else if (state == S_LDA_GAP) begin
        mul_ui <= b_q;
      end

      // Arm flag: cleared on entry to START. It is set by any cycle with
      // done low, including the START cycle itself.
      if (state == S_LDB_GAP) begin
        armed <= 1'b0;
      end else if (!mul_done) begin
        armed <= 1'b1;
      end

      // WAIT_DONE cycle counter, cleared whenever outside WAIT_DONE
      if (state == S_WAIT_DONE) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'h00;
      end

      // Low byte is sampled at the end of the second out_sel = 0 cycle. This
      // gives the multiplier's output mux a full cycle to settle.
      if (state == S_RD_LO_CAP) begin
        lo_q <= mul_uo;
      end

      // Result register: loaded on entry to OUT, held through OUT
      if (result_load) begin
        res_data <= result_next;
        res_err  <= result_err_next;
        if (result_err_next) begin
          err_sticky <= 1'b1;
        end
      end else if ((state == S_OUT) && res_ready) begin
        res_err <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional product self-check
  // -------------------------------------------------------------------------
`ifdef MULT8_HOST_SEQ_CHECK_EN
  logic [15:0] ref_prod;

  assign ref_prod = {8'h00, a_q} * {8'h00, b_q};

  // The flag is registered together with the result so that it is stable
  // for the whole time res_valid is high. A timed-out result is never
  // flagged, because res_err already marks it as bad.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_mismatch <= 1'b0;
    end else if (result_load) begin
      res_mismatch <= (result_next != ref_prod) && !result_err_next;
    end else if ((state == S_OUT) && res_ready) begin
      res_mismatch <= 1'b0;
    end
  end
`else
  assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mult8_host_seq.sv
// ---------------------------------------------------------------------------
// tb_mult8_host_seq
//
// Bench for mult8_host_seq. A behavioural model of the byte-serial
// multiplier sits on the mul_* port. The model's done timing is
// configurable: normal, stale done, never done, or a corrupted product.
// Expected products come from plain arithmetic. Expected timing follows the
// documented schedule of the sequencer, counted in edges after the accepting
// edge:
//   load_a at 0, load_b at 2, start at 4, WAIT_DONE from 6.
//   With a good result, res_valid is at 10 + W and out_sel is 1 at
//   8 + W and 9 + W.
//   After a timeout, res_valid is at 6 + TIMEOUT.
// ---------------------------------------------------------------------------
module tb_mult8_host_seq;

  localparam int TIMEOUT = 64;

`ifdef MULT8_HOST_SEQ_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a      = 8'h00;
  logic [7:0]  in_b      = 8'h00;
  logic [7:0]  mul_ui;
  logic        mul_load_a;
  logic        mul_load_b;
  logic        mul_start;
  logic        mul_out_sel;
  logic [7:0]  mul_uo;
  logic        mul_done;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_err;
  logic        err_sticky;
  logic        res_mismatch;

  mult8_host_seq #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mul_ui       (mul_ui),
    .mul_load_a   (mul_load_a),
    .mul_load_b   (mul_load_b),
    .mul_start    (mul_start),
    .mul_out_sel  (mul_out_sel),
    .mul_uo       (mul_uo),
    .mul_done     (mul_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_err      (res_err),
    .err_sticky   (err_sticky),
    .res_mismatch (res_mismatch)
  );

  // ---------------- multiplier model ----------------
  // model_mode: 0 normal, 1 stale done (done drops 2 edges after start),
  //             2 never done, 3 product corrupted in bit 0
  int          model_mode = 0;
  int          done_delay = 8;
  logic [7:0]  m_a        = 8'h00;
  logic [7:0]  m_b        = 8'h00;
  logic [15:0] m_prod     = 16'h0000;
  logic        m_done     = 1'b0;
  int          m_cnt      = 0;
  int          m_drop     = 0;

  always @(posedge clk) begin
    if (mul_load_a) m_a <= mul_ui;
    if (mul_load_b) m_b <= mul_ui;
    if (mul_start) begin
      m_cnt <= (model_mode == 2) ? 0 : done_delay;
      if (model_mode == 1) m_drop <= 2;
      else                 m_done <= 1'b0;
    end else begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_prod <= (model_mode == 3) ? ((16'(m_a) * 16'(m_b)) ^ 16'h0001)
                                    : (16'(m_a) * 16'(m_b));
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (m_drop == 1) m_done <= 1'b0;
      if (m_drop != 0) m_drop <= m_drop - 1;
    end
  end

  assign mul_done = m_done;
  assign mul_uo   = mul_out_sel ? m_prod[15:8] : m_prod[7:0];

  // ---------------- scoreboard ----------------
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic exp_sticky = 1'b0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits for in_ready, presents the pair, and returns at the negedge right
  // after the accepting edge (edge count 0).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, ":ready_wait"}, 32'(t < 50), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitors an operation from edge count 0 up to res_valid and checks the
  // schedule and the result. Leaves res_valid pending.
  task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input logic exp_e,
                           input logic exp_mm, input int w, input string tag);
    int n = 0;
    int strobe_bad = 0;
    int sel_bad = 0;
    int exp_lat;
    logic [15:0] exp_d;
    exp_d   = exp_q.pop_front();
    exp_lat = exp_e ? 6 + TIMEOUT : 10 + w;
    while (res_valid !== 1'b1 && n < 400) begin
      if (n == 0 || n == 1) check({tag, ":ui_a"}, 32'(mul_ui), 32'(a));
      if (n == 2 || n == 3) check({tag, ":ui_b"}, 32'(mul_ui), 32'(b));
      if ({mul_load_a, mul_load_b, mul_start} !== {n == 0, n == 2, n == 4}) strobe_bad++;
      if (mul_out_sel !== (!exp_e && (n == 8 + w || n == 9 + w))) sel_bad++;
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(exp_lat));
    check({tag, ":strobe_seq"}, 32'(strobe_bad), 32'd0);
    check({tag, ":out_sel_seq"}, 32'(sel_bad), 32'd0);
    check({tag, ":res_data"}, 32'(res_data), 32'(exp_d));
    check({tag, ":res_err"}, 32'(res_err), 32'(exp_e));
    check({tag, ":err_sticky"}, 32'(err_sticky), 32'(exp_sticky));
    check({tag, ":res_mismatch"}, 32'(res_mismatch), 32'(exp_mm));
  endtask

  task automatic release_op(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ":rel_valid"}, 32'(res_valid), 32'd0);
    check({tag, ":rel_ready"}, 32'(in_ready), 32'd1);
    check({tag, ":rel_err"}, 32'(res_err), 32'd0);
  endtask

  task automatic good_op(input logic [7:0] a, input logic [7:0] b, input int w, input string tag);
    done_delay = w;
    model_mode = 0;
    exp_q.push_back(16'(a) * 16'(b));
    start_op(a, b, tag);
    finish_op(a, b, 1'b0, 1'b0, w, tag);
    release_op(tag);
  endtask

  task automatic check_idle_after_reset(input string tag);
    check({tag, ":strobes"}, 32'({mul_load_a, mul_load_b, mul_start, mul_out_sel}), 32'd0);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ":res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ":err_sticky"}, 32'(err_sticky), 32'd0);
  endtask

  // ---------------- directed / random sequence ----------------
  logic [7:0] dir_a [4] = '{8'h01, 8'hAA, 8'h7F, 8'hFF};
  logic [7:0] dir_b [4] = '{8'hFF, 8'h0F, 8'h80, 8'hFF};

  initial begin
    logic [7:0] ra, rb;
    logic [15:0] held;
    int rw;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:strobes", 32'({mul_load_a, mul_load_b, mul_start, mul_out_sel}), 32'd0);
    check("rst:mul_ui", 32'(mul_ui), 32'd0);
    check("rst:res_valid", 32'(res_valid), 32'd0);
    check("rst:res_data", 32'(res_data), 32'd0);
    check("rst:res_err", 32'(res_err), 32'd0);
    check("rst:err_sticky", 32'(err_sticky), 32'd0);
    check("rst:res_mismatch", 32'(res_mismatch), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero operands, then the directed products
    good_op(8'h00, 8'h00, 8, "zero");
    for (int i = 0; i < 4; i++) good_op(dir_a[i], dir_b[i], 8, $sformatf("dir%0d", i));

    // Stale done: done held high from the previous op, dropped 2 edges after start
    model_mode = 1;
    done_delay = 8;
    exp_q.push_back(16'h12 * 16'h34);
    start_op(8'h12, 8'h34, "stale");
    finish_op(8'h12, 8'h34, 1'b0, 1'b0, 8, "stale");
    release_op("stale");

    // Random operands and done delays
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rw = $urandom_range(1, 12);
      good_op(ra, rb, rw, $sformatf("rnd%0d", i));
    end

    // Timeout: done never rises
    model_mode = 2;
    exp_sticky = 1'b1;
    exp_q.push_back(16'hFFFF);
    start_op(8'h5A, 8'hA5, "timeout");
    finish_op(8'h5A, 8'hA5, 1'b1, 1'b0, 0, "timeout");
    release_op("timeout");
    good_op(8'h33, 8'h03, 8, "after_to");

    // Backpressure: res_ready low for 20 cycles while new operands wait
    done_delay = 5;
    model_mode = 0;
    exp_q.push_back(16'h21 * 16'h43);
    start_op(8'h21, 8'h43, "bp1");
    finish_op(8'h21, 8'h43, 1'b0, 1'b0, 5, "bp1");
    held     = 16'h21 * 16'h43;
    in_valid = 1'b1;
    in_a     = 8'hC3;
    in_b     = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp:res_valid", 32'(res_valid), 32'd1);
      check("bp:res_data", 32'(res_data), 32'(held));
      check("bp:in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp:idle_ready", 32'(in_ready), 32'd1);
    check("bp:idle_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp:accept_next", 32'(mul_load_a), 32'd1);
    exp_q.push_back(16'hC3 * 16'h3C);
    finish_op(8'hC3, 8'h3C, 1'b0, 1'b0, 5, "bp2");
    release_op("bp2");

    // Corrupted product from the multiplier
    done_delay = 8;
    model_mode = 3;
    exp_q.push_back(16'h09F7);
    start_op(8'hAA, 8'h0F, "mism");
    finish_op(8'hAA, 8'h0F, 1'b0, CHECK_EN, 8, "mism");
    release_op("mism");
    model_mode = 0;

    // Reset during WAIT_DONE (edge count 7 with W = 8)
    start_op(8'h44, 8'h55, "rst_wait");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_sticky = 1'b0;
    check_idle_after_reset("rst_wait");

    // Reset during RD_HI_SET (edge count 8 + W = 16)
    start_op(8'h66, 8'h77, "rst_hi");
    repeat (16) @(negedge clk);
    check("rst_hi:sel_before", 32'(mul_out_sel), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_after_reset("rst_hi");

    // Recovery after reset
    good_op(8'h9C, 8'hE7, 8, "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog against an unexpected hang
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
